// File: rtl/spi_logic_slave.sv
// ============================================================================
// Module      : spi_logic_slave
// Description : Mode-0 SPI responder, MSB first, 8/16/24/32-bit frames,
//               with all pins oversampled in the clk_cpu domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_logic_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk_cpu,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] SPI_DATA_OUT,
  output logic [DATA_WIDTH-1:0] SPI_DATA_IN,
  input  logic [3:0]            SPI_CTRL,
  input  logic                  SCK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  output logic                  BUSY,
  output logic                  OVERRUN,
  output logic                  IRQ_SPI
);

  localparam logic [5:0]            c_dw   = 6'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] c_ones = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_WAIT_SS = 2'd2
  } state_t;

  // Synchronizers; MOSI taps the same depth as SCK so it is sampled delay-matched.
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_ss_d;

  logic w_sck_s, w_ss_s, w_mosi_s;
  logic w_rise, w_fall, w_ss_fall, w_ss_rise;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_len, w_len_nxt;
  logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
  logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
  logic [5:0]            r_cnt, w_cnt_nxt;
  logic                  r_oe, w_oe_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_irq, w_irq_nxt;
  logic                  r_ovr, w_ovr_nxt;
  logic [DATA_WIDTH-1:0] r_data_in, w_data_in_nxt;

  logic                  w_complete;
  logic [5:0]            w_nbits;
  logic [5:0]            w_new_nbits;
  logic [DATA_WIDTH-1:0] w_dout_lj;
  logic [DATA_WIDTH-1:0] w_mask;

  function automatic logic [5:0] len_to_bits(input logic [1:0] len);
    logic [5:0] bits;
    case (len)
      2'b00:   bits = 6'd8;
      2'b01:   bits = 6'd16;
      2'b10:   bits = 6'd24;
      default: bits = 6'd32;
    endcase
    return bits;
  endfunction

  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sck_d     <= w_sck_s;
      r_ss_d      <= w_ss_s;
    end
  end

  assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    =  w_sck_s & ~r_sck_d;
  assign w_fall    = ~w_sck_s &  r_sck_d;
  assign w_ss_fall = ~w_ss_s  &  r_ss_d;
  assign w_ss_rise =  w_ss_s  & ~r_ss_d;

  assign w_nbits     = len_to_bits(r_len);
  assign w_new_nbits = len_to_bits(SPI_CTRL[2:1]);
  // Transmit word is parked MSB-aligned so MISO always comes from the top bit.
  assign w_dout_lj   = SPI_DATA_OUT << (c_dw - w_new_nbits);
  assign w_mask      = c_ones >> (c_dw - w_nbits);

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_cnt_nxt     = r_cnt;
    w_oe_nxt      = r_oe;
    w_busy_nxt    = r_busy;
    w_irq_nxt     = r_irq;
    w_ovr_nxt     = r_ovr;
    w_data_in_nxt = r_data_in;
    w_complete    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_ss_fall && SPI_CTRL[0]) begin
          w_len_nxt   = SPI_CTRL[2:1];
          w_tx_nxt    = w_dout_lj;
          w_rx_nxt    = '0;
          w_cnt_nxt   = 6'd0;
          w_oe_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (r_cnt == w_nbits) begin
          w_complete  = 1'b1;
          w_tx_nxt    = '0;
          w_state_nxt = S_WAIT_SS;
          if (w_ss_rise) begin
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else if (w_ss_rise) begin
          // Abort: the partial word is dropped, SPI_DATA_IN and IRQ untouched.
          w_rx_nxt    = '0;
          w_tx_nxt    = '0;
          w_oe_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_rx_nxt  = {r_rx[DATA_WIDTH-2:0], w_mosi_s};
          w_cnt_nxt = r_cnt + 6'd1;
        end else if (w_fall && (r_cnt < w_nbits)) begin
          w_tx_nxt = r_tx << 1;
        end
      end

      S_WAIT_SS: begin
        w_tx_nxt = '0;
        if (w_ss_rise) begin
          w_oe_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_tx_nxt    = '0;
        w_oe_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Completion beats a coincident ack; the ack still clears the old overrun.
    if (w_complete) begin
      w_data_in_nxt = r_rx & w_mask;
      w_irq_nxt     = 1'b1;
      w_ovr_nxt     = SPI_CTRL[3] ? 1'b0 : (r_ovr | r_irq);
    end else if (SPI_CTRL[3]) begin
      w_irq_nxt = 1'b0;
      w_ovr_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_len     <= 2'b00;
      r_tx      <= '0;
      r_rx      <= '0;
      r_cnt     <= 6'd0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
      r_ovr     <= 1'b0;
      r_data_in <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_oe      <= w_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_irq     <= w_irq_nxt;
      r_ovr     <= w_ovr_nxt;
      r_data_in <= w_data_in_nxt;
    end
  end

  assign MISO        = r_tx[DATA_WIDTH-1] & r_oe;
  assign MISO_OE     = r_oe;
  assign BUSY        = r_busy;
  assign OVERRUN     = r_ovr;
  assign IRQ_SPI     = r_irq;
  assign SPI_DATA_IN = r_data_in;

endmodule

`default_nettype wire

// File: tb/tb_spi_logic_slave.sv
// ============================================================================
// Module      : tb_spi_logic_slave
// Description : Directed-vector bench for spi_logic_slave with an SPI master model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_logic_slave;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;

  logic        clk_cpu = 1'b0;
  logic        rst     = 1'b0;
  logic [31:0] SPI_DATA_OUT = 32'h0;
  logic [31:0] SPI_DATA_IN;
  logic [3:0]  SPI_CTRL = 4'h0;
  logic        SCK  = 1'b0;
  logic        SS   = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, MISO_OE, BUSY, OVERRUN, IRQ_SPI;

  spi_logic_slave #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(32)) dut (
    .clk_cpu      (clk_cpu),
    .rst          (rst),
    .SPI_DATA_OUT (SPI_DATA_OUT),
    .SPI_DATA_IN  (SPI_DATA_IN),
    .SPI_CTRL     (SPI_CTRL),
    .SCK          (SCK),
    .SS           (SS),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .MISO_OE      (MISO_OE),
    .BUSY         (BUSY),
    .OVERRUN      (OVERRUN),
    .IRQ_SPI      (IRQ_SPI)
  );

  always #5 clk_cpu = ~clk_cpu;

  int   checks = 0;
  int   errors = 0;
  int   irq_edges = 0;
  int   irq_lat = -1;
  logic irq_prev = 1'b0;
  logic oe_seen = 1'b0;
  logic miso_bad = 1'b0;
  logic busy_mid = 1'b0;

  typedef struct {
    logic [1:0]  len;
    logic [31:0] dout;
    logic [31:0] mosi;
    int          nrises;
    logic        ack_pre;
    logic [31:0] exp_din;
    logic [31:0] exp_miso;
    logic        exp_irq;
    logic        exp_ovr;
    int          exp_edges;
  } vec_t;

  vec_t vecs [7];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_cpu);
      #1;
      if (IRQ_SPI && !irq_prev) irq_edges++;
      irq_prev = IRQ_SPI;
      if (MISO_OE) oe_seen = 1'b1;
      if (!MISO_OE && MISO) miso_bad = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic ack_pulse();
    SPI_CTRL[3] = 1'b1;
    tick(1);
    SPI_CTRL[3] = 1'b0;
    tick(1);
  endtask

  // Master model; scrambles SPI_CTRL/SPI_DATA_OUT after the first rise to
  // show the frame in flight is unaffected.
  task automatic spi_frame(input logic en, input logic [1:0] len, input logic [31:0] dout,
                           input logic [31:0] mosi_word, input int nrises,
                           input logic hold_ack, output logic [31:0] miso_word);
    int nbits;
    nbits        = 8 * (int'(len) + 1);
    miso_word    = 32'h0;
    irq_edges    = 0;
    irq_lat      = -1;
    oe_seen      = 1'b0;
    busy_mid     = 1'b0;
    SPI_CTRL     = {hold_ack, len, en};
    SPI_DATA_OUT = dout;
    tick(1);
    SS   = 1'b0;
    MOSI = mosi_word[nrises-1];
    tick(HALF);
    for (int i = 0; i < nrises; i++) begin
      miso_word = {miso_word[30:0], MISO};
      SCK = 1'b1;
      if (i == 0) begin
        busy_mid      = BUSY;
        SPI_DATA_OUT  = ~dout;
        SPI_CTRL[2:0] = {~len, 1'b0};
      end
      for (int c = 1; c <= HALF; c++) begin
        tick(1);
        if (i == nbits - 1) begin
          if (IRQ_SPI && irq_lat < 0) irq_lat = c;
          if (hold_ack && c == 4) SPI_CTRL[3] = 1'b0;
        end
      end
      SCK = 1'b0;
      if (i + 1 < nrises) MOSI = mosi_word[nrises-2-i];
      tick(HALF);
    end
    tick(4);
    SS = 1'b1;
    tick(8);
    SPI_CTRL = 4'b0001;
  endtask

  initial begin
    logic [31:0] mw;
    logic        lat_ok;

    vecs[0] = '{2'b00, 32'h0000_00A5, 32'h0000_003C,  8, 1'b1, 32'h0000_003C, 32'h0000_00A5, 1'b1, 1'b0, 1};
    vecs[1] = '{2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 32, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b0, 1};
    vecs[2] = '{2'b01, 32'h5555_BEEF, 32'h0000_CAFE, 16, 1'b1, 32'h0000_CAFE, 32'h0000_BEEF, 1'b1, 1'b0, 1};
    vecs[3] = '{2'b10, 32'hFFAB_CDEF, 32'h0012_3456, 24, 1'b1, 32'h0012_3456, 32'h00AB_CDEF, 1'b1, 1'b0, 1};
    vecs[4] = '{2'b00, 32'h0000_005A, 32'h0000_02B5, 10, 1'b1, 32'h0000_00AD, 32'h0000_0168, 1'b1, 1'b0, 1};
    vecs[5] = '{2'b00, 32'h0000_0011, 32'h0000_0011,  8, 1'b1, 32'h0000_0011, 32'h0000_0011, 1'b1, 1'b0, 1};
    vecs[6] = '{2'b00, 32'h0000_0022, 32'h0000_0022,  8, 1'b0, 32'h0000_0022, 32'h0000_0022, 1'b1, 1'b1, 0};

    // Reset held with SS low and SCK toggling.
    rst = 1'b0;
    SS  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      SCK = ~SCK;
      tick(2);
    end
    check("reset_flags", {27'h0, MISO, MISO_OE, BUSY, OVERRUN, IRQ_SPI}, 32'h0);
    check("reset_data_in", SPI_DATA_IN, 32'h0);
    SCK = 1'b0;
    SS  = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(6);
    check("post_reset_busy", {31'h0, BUSY}, 32'h0);
    check("post_reset_oe", {31'h0, MISO_OE}, 32'h0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].ack_pre) ack_pulse();
      spi_frame(1'b1, vecs[v].len, vecs[v].dout, vecs[v].mosi, vecs[v].nrises, 1'b0, mw);
      check($sformatf("v%0d_data_in", v), SPI_DATA_IN, vecs[v].exp_din);
      check($sformatf("v%0d_miso", v), mw, vecs[v].exp_miso);
      check($sformatf("v%0d_irq", v), {31'h0, IRQ_SPI}, {31'h0, vecs[v].exp_irq});
      check($sformatf("v%0d_overrun", v), {31'h0, OVERRUN}, {31'h0, vecs[v].exp_ovr});
      check($sformatf("v%0d_irq_edges", v), irq_edges, vecs[v].exp_edges);
      check($sformatf("v%0d_busy_mid", v), {31'h0, busy_mid}, 32'h1);
      check($sformatf("v%0d_idle_flags", v), {30'h0, BUSY, MISO_OE}, 32'h0);
      if (vecs[v].ack_pre) begin
        lat_ok = (irq_lat >= 1) && (irq_lat <= SYNC_STAGES + 3);
        check($sformatf("v%0d_irq_latency(%0d)", v, irq_lat), {31'h0, lat_ok}, 32'h1);
      end
    end

    // Ack clears both IRQ and OVERRUN.
    ack_pulse();
    check("ack_irq", {31'h0, IRQ_SPI}, 32'h0);
    check("ack_overrun", {31'h0, OVERRUN}, 32'h0);

    // Abort after 9 of 16 bits, then a clean 16-bit frame.
    spi_frame(1'b1, 2'b01, 32'h0000_7777, 32'h0000_01FF, 9, 1'b0, mw);
    check("abort_data_in", SPI_DATA_IN, 32'h0000_0022);
    check("abort_irq", {31'h0, IRQ_SPI}, 32'h0);
    check("abort_flags", {30'h0, BUSY, MISO_OE}, 32'h0);
    spi_frame(1'b1, 2'b01, 32'h0000_4321, 32'h0000_8001, 16, 1'b0, mw);
    check("after_abort_data_in", SPI_DATA_IN, 32'h0000_8001);
    check("after_abort_miso", mw, 32'h0000_4321);
    check("after_abort_irq", {31'h0, IRQ_SPI}, 32'h1);

    // Ack held until exactly the completion cycle: completion wins.
    spi_frame(1'b1, 2'b00, 32'h0000_0096, 32'h0000_0069, 8, 1'b1, mw);
    check("coincide_irq", {31'h0, IRQ_SPI}, 32'h1);
    check("coincide_overrun", {31'h0, OVERRUN}, 32'h0);
    check("coincide_data_in", SPI_DATA_IN, 32'h0000_0069);
    check("coincide_miso", mw, 32'h0000_0096);

    // Disabled at ss_fall: block ignores the whole frame.
    ack_pulse();
    spi_frame(1'b0, 2'b00, 32'h0000_00FF, 32'h0000_00AA, 8, 1'b0, mw);
    check("disabled_oe_seen", {31'h0, oe_seen}, 32'h0);
    check("disabled_irq", {31'h0, IRQ_SPI}, 32'h0);
    check("disabled_busy", {31'h0, busy_mid}, 32'h0);
    check("disabled_data_in", SPI_DATA_IN, 32'h0000_0069);
    spi_frame(1'b1, 2'b00, 32'h0000_000F, 32'h0000_00F0, 8, 1'b0, mw);
    check("reenabled_data_in", SPI_DATA_IN, 32'h0000_00F0);
    check("reenabled_miso", mw, 32'h0000_000F);

    check("miso_low_when_not_oe", {31'h0, miso_bad}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_logic_slave.md
Name: spi_logic_slave

Overview:
- SPI responder (slave) for the SoC peripheral bus. It is the far-end counterpart of the SPI master logic block.
- Supports mode 0 only (CPOL=0, CPHA=0), MSB first, with a frame length of 8, 16, 24 or 32 bits.
- SCK, SS and MOSI are oversampled in the clk_cpu domain. The block presents received words on SPI_DATA_IN and raises IRQ_SPI to the CPU.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCK/SS/MOSI (allowed values 2..3)
- DATA_WIDTH, 32, width of the TX and RX words (fixed at 32 for this release)

Ports:
- clk_cpu  input  1  system clock
- rst  input  1  asynchronous active-low reset
- SPI_DATA_OUT  input  32  word to transmit; right-aligned, bits [N-1:0] are sent
- SPI_DATA_IN  output  32  last complete received word; right-aligned, upper bits zero
- SPI_CTRL  input  4  [0] enable, [2:1] length (00=8, 01=16, 10=24, 11=32), [3] irq_ack (level)
- SCK  input  1  serial clock from master
- SS  input  1  slave select, active low
- MOSI  input  1  master-out data
- MISO  output  1  slave-out data
- MISO_OE  output  1  tri-state enable for the MISO pad
- BUSY  output  1  frame in progress
- OVERRUN  output  1  frame completed while IRQ_SPI was still set
- IRQ_SPI  output  1  frame-complete interrupt, level

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift registers=0, bit counter=0, SPI_DATA_IN=0. Outputs MISO=0, MISO_OE=0, BUSY=0, OVERRUN=0, IRQ_SPI=0. Synchronizer flops reset: SS to 1, SCK/MOSI to 0.
- Synchronization: SCK, SS and MOSI each pass through SYNC_STAGES flops plus one history flop.
  - rise/fall/ss_fall/ss_rise are single-cycle strobes, SYNC_STAGES+1 clk_cpu cycles after the pin event.
  - MOSI is sampled from its own synchronized copy, which is delay-matched to SCK.
- Timing requirements on the master:
  - SCK high and low phases >= 4 clk_cpu cycles each.
  - SS-low to first SCK rise >= 4 clk_cpu cycles.
- States:
  - IDLE
    - On ss_fall with SPI_CTRL[0]=1: latch length N from SPI_CTRL[2:1] and load tx_shift <= SPI_DATA_OUT left-justified to bit N-1.
    - Same cycle: bit counter=0, MISO=SPI_DATA_OUT[N-1], MISO_OE=1, BUSY=1, go to ACTIVE.
    - ss_fall with enable=0 is ignored; the block stays IDLE for the whole SS-low period.
  - ACTIVE
    - On rise: rx_shift <= {rx_shift[30:0], mosi_s}, counter++.
    - On fall: if counter<N, shift tx_shift and drive the next bit on MISO.
    - When counter reaches N on a rise:
      - Next cycle: SPI_DATA_IN <= rx_shift masked to N bits, IRQ_SPI=1.
      - If IRQ_SPI was already 1, also set OVERRUN=1.
      - Go to WAIT_SS.
  - WAIT_SS
    - Further SCK edges are ignored; MISO holds 0.
    - On ss_rise: MISO_OE=0, BUSY=0, go to IDLE.
- Abort: ss_rise in ACTIVE before N bits: discard rx_shift, leave SPI_DATA_IN and IRQ_SPI unchanged, MISO_OE=0, BUSY=0, go to IDLE.
- SPI_CTRL changes while BUSY=1 have no effect on the current frame. The length is latched only at ss_fall.
- SPI_DATA_OUT is sampled only at ss_fall; later changes do not affect the frame in flight.
- IRQ_SPI and OVERRUN both clear on any cycle with SPI_CTRL[3]=1 and no simultaneous frame completion.
  - If ack and completion coincide, completion wins: IRQ_SPI stays 1.
  - OVERRUN is cleared in that case, since the previous IRQ was acknowledged.
- Disabling (SPI_CTRL[0]=0) mid-frame does not abort; it blocks only the next ss_fall.
- MISO=0 whenever MISO_OE=0.

Test Plan:
- Reset: hold rst=0 with SCK toggling and SS=0 -> all outputs 0. Release rst with SS=1 -> IDLE, BUSY=0.
- 8-bit frame: len=00, SPI_DATA_OUT=0x000000A5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; SPI_DATA_IN=0x0000003C; IRQ_SPI=1 within SYNC_STAGES+3 clk_cpu cycles of the 8th SCK rise.
- 32-bit frame: len=11, SPI_DATA_OUT=0xDEADBEEF, master sends 0x12345678 -> master receives 0xDEADBEEF; SPI_DATA_IN=0x12345678.
- Abort: len=01, SS raised after 9 SCK rises -> SPI_DATA_IN keeps its previous value, IRQ_SPI unchanged, BUSY=0, MISO_OE=0. The next 16-bit frame completes normally.
- Overrun and ack:
  - Two 8-bit frames (0x11 then 0x22) with no ack -> SPI_DATA_IN=0x22, OVERRUN=1.
  - Pulse SPI_CTRL[3] -> IRQ_SPI=0, OVERRUN=0.
  - Ack coinciding with frame completion -> IRQ_SPI stays 1.
- Extra clocks and disable:
  - 10 SCK pulses on an 8-bit frame -> SPI_DATA_IN holds the first 8 bits; IRQ_SPI raised once.
  - Enable=0 at ss_fall -> no MISO_OE, no IRQ.
